// File: rtl/access_signal_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : access_signal_decoder
//  Description : Synchronises and glitch-filters the active-low bubble control
//                strobes, sequences them through an IDLE/ARMED/SHIFT access
//                state machine and drives clean active-high enables, access
//                ticks and protocol-error pulses for the bubble timing
//                generator.
//  Revision    : 1.0 - initial release
// ============================================================================
module access_signal_decoder #(
    parameter int FILTER_LEN    = 4,
    parameter int ARM_TIMEOUT   = 48000,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic master_clock,
    input  logic master_reset,
    input  logic bubble_module_enable,
    input  logic n_bss,
    input  logic n_bsen,
    input  logic n_repen,
    input  logic n_booten,
    input  logic n_swapen,
    output logic bubble_shift_enable,
    output logic replicator_enable,
    output logic bootloop_enable,
    output logic swap_enable,
    output logic access_start_tick,
    output logic access_end_tick,
    output logic access_error
);

    // Bit positions of each strobe inside the input vectors
    localparam int c_BSS    = 0;
    localparam int c_BSEN   = 1;
    localparam int c_REPEN  = 2;
    localparam int c_BOOTEN = 3;
    localparam int c_SWAPEN = 4;
    localparam int c_NIN    = 5;

    localparam logic [3:0]               c_FILT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] c_ARM_LAST  = TIMEOUT_WIDTH'(ARM_TIMEOUT - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] c_ARM_ONE   = TIMEOUT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    logic [c_NIN-1:0] w_raw;
    logic [c_NIN-1:0] r_sync1;
    logic [c_NIN-1:0] r_sync2;
    logic [c_NIN-1:0] w_filt;
    logic             r_bss_d1;
    logic             r_bsen_d1;
    logic             w_bss_rise;
    logic             w_bsen_rise;
    logic             w_bsen_fall;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [TIMEOUT_WIDTH-1:0] r_arm_cnt;
    logic [TIMEOUT_WIDTH-1:0] w_arm_cnt_nxt;
    logic                     r_boot;
    logic                     w_boot_nxt;
    logic                     w_start_nxt;
    logic                     w_end_nxt;
    logic                     w_err_nxt;
    logic                     r_shift;
    logic                     r_rep;
    logic                     r_swap;
    logic                     r_start;
    logic                     r_end;
    logic                     r_err;

    // Strobes are active low on the connector; work internally active high
    assign w_raw = ~{n_swapen, n_booten, n_repen, n_bsen, n_bss};

    // Two-flop synchroniser for every asynchronous strobe
    always_ff @(posedge master_clock or posedge master_reset) begin
        if (master_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar gi = 0; gi < c_NIN; gi++) begin : g_filter
            logic [3:0] r_stab_cnt;
            logic       r_level;

            // Level follows the synchronised input only after it has differed for FILTER_LEN cycles
            always_ff @(posedge master_clock or posedge master_reset) begin
                if (master_reset) begin
                    r_stab_cnt <= 4'd0;
                    r_level    <= 1'b0;
                end else if (r_sync2[gi] == r_level) begin
                    r_stab_cnt <= 4'd0;
                end else if (r_stab_cnt == c_FILT_LAST) begin
                    r_level    <= r_sync2[gi];
                    r_stab_cnt <= 4'd0;
                end else begin
                    r_stab_cnt <= r_stab_cnt + 4'd1;
                end
            end

            assign w_filt[gi] = r_level;
        end
    endgenerate

    // Previous filtered levels of the strobes whose edges drive the FSM; these
    // track even while disabled so stale edges are never replayed
    always_ff @(posedge master_clock or posedge master_reset) begin
        if (master_reset) begin
            r_bss_d1  <= 1'b0;
            r_bsen_d1 <= 1'b0;
        end else begin
            r_bss_d1  <= w_filt[c_BSS];
            r_bsen_d1 <= w_filt[c_BSEN];
        end
    end

    assign w_bss_rise  = w_filt[c_BSS]  & ~r_bss_d1;
    assign w_bsen_rise = w_filt[c_BSEN] & ~r_bsen_d1;
    assign w_bsen_fall = ~w_filt[c_BSEN] & r_bsen_d1;

    // Access sequencing: next state, timeout count, bootloop latch and tick requests
    always_comb begin
        w_state_nxt   = r_state;
        w_arm_cnt_nxt = r_arm_cnt;
        w_boot_nxt    = r_boot;
        w_start_nxt   = 1'b0;
        w_end_nxt     = 1'b0;
        w_err_nxt     = 1'b0;

        if (!bubble_module_enable) begin
            w_state_nxt   = ST_IDLE;
            w_arm_cnt_nxt = '0;
            w_boot_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_bss_rise) begin
                        w_state_nxt   = ST_ARMED;
                        w_arm_cnt_nxt = '0;
                        w_boot_nxt    = w_filt[c_BOOTEN];
                    end else if (w_bsen_rise) begin
                        w_err_nxt = 1'b1;
                    end
                end
                ST_ARMED: begin
                    // bsen is tested as a level so a same-cycle bss/bsen pair still starts
                    if (w_filt[c_BSEN]) begin
                        w_state_nxt = ST_SHIFT;
                        w_start_nxt = 1'b1;
                    end else if (r_arm_cnt == c_ARM_LAST) begin
                        w_state_nxt   = ST_IDLE;
                        w_err_nxt     = 1'b1;
                        w_boot_nxt    = 1'b0;
                        w_arm_cnt_nxt = '0;
                    end else begin
                        w_arm_cnt_nxt = r_arm_cnt + c_ARM_ONE;
                    end
                end
                ST_SHIFT: begin
                    if (w_bsen_fall) begin
                        w_state_nxt = ST_IDLE;
                        w_end_nxt   = 1'b1;
                        w_boot_nxt  = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_arm_cnt_nxt = '0;
                    w_boot_nxt    = 1'b0;
                end
            endcase
        end
    end

    // State register and registered outputs derived from the next state
    always_ff @(posedge master_clock or posedge master_reset) begin
        if (master_reset) begin
            r_state   <= ST_IDLE;
            r_arm_cnt <= '0;
            r_boot    <= 1'b0;
            r_shift   <= 1'b0;
            r_rep     <= 1'b0;
            r_swap    <= 1'b0;
            r_start   <= 1'b0;
            r_end     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_arm_cnt <= w_arm_cnt_nxt;
            r_boot    <= w_boot_nxt;
            r_shift   <= (w_state_nxt == ST_SHIFT);
            r_rep     <= (w_state_nxt == ST_SHIFT) & w_filt[c_REPEN];
            r_swap    <= bubble_module_enable & w_filt[c_SWAPEN];
            r_start   <= w_start_nxt;
            r_end     <= w_end_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign bubble_shift_enable = r_shift;
    assign replicator_enable   = r_rep;
    assign bootloop_enable     = r_boot;
    assign swap_enable         = r_swap;
    assign access_start_tick   = r_start;
    assign access_end_tick     = r_end;
    assign access_error        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_access_signal_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_access_signal_decoder
//  Description : Self-checking bench for access_signal_decoder. Expected
//                outputs come from a timeline model: each raw strobe change
//                shows up at the outputs FILTER_LEN+3 cycles later, pulses
//                shorter than FILTER_LEN are dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_access_signal_decoder;

    localparam int FL  = 4;
    localparam int TMO = 100;
    localparam int DLY = FL + 3;   // raw change to registered output

    logic master_clock = 1'b0;
    logic master_reset = 1'b1;
    logic bubble_module_enable = 1'b1;
    logic n_bss = 1'b1, n_bsen = 1'b1, n_repen = 1'b1, n_booten = 1'b1, n_swapen = 1'b1;
    logic bubble_shift_enable, replicator_enable, bootloop_enable, swap_enable;
    logic access_start_tick, access_end_tick, access_error;

    int checks   = 0;
    int failures = 0;

    // Trial description: kind 0 = full access, 1 = arm timeout, 2 = idle bsen pulse
    int kind, g, r, len, a, w, ga, gw;
    bit b;

    access_signal_decoder #(
        .FILTER_LEN   (FL),
        .ARM_TIMEOUT  (TMO),
        .TIMEOUT_WIDTH(16)
    ) dut (
        .master_clock        (master_clock),
        .master_reset        (master_reset),
        .bubble_module_enable(bubble_module_enable),
        .n_bss               (n_bss),
        .n_bsen              (n_bsen),
        .n_repen             (n_repen),
        .n_booten            (n_booten),
        .n_swapen            (n_swapen),
        .bubble_shift_enable (bubble_shift_enable),
        .replicator_enable   (replicator_enable),
        .bootloop_enable     (bootloop_enable),
        .swap_enable         (swap_enable),
        .access_start_tick   (access_start_tick),
        .access_end_tick     (access_end_tick),
        .access_error        (access_error)
    );

    always #5 master_clock = ~master_clock;

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    function automatic int bss_end();
        return (kind == 0) ? g + 6 : 110;
    endfunction

    function automatic int t_start();
        return (g == 0) ? DLY + 1 : g + DLY;
    endfunction

    function automatic int t_end();
        return g + len + DLY;
    endfunction

    function automatic logic e_shift(input int t);
        return (kind == 0) && t >= t_start() && t < t_end();
    endfunction

    function automatic logic e_rep(input int t);
        int lo;
        lo = (g + r + DLY > t_start()) ? g + r + DLY : t_start();
        return (kind == 0) && t >= lo && t < t_end();
    endfunction

    function automatic logic e_boot(input int t);
        if (!b || kind == 2) return 1'b0;
        if (kind == 0) return t >= DLY && t < t_end();
        return t >= DLY && t < DLY + TMO;
    endfunction

    function automatic logic e_err(input int t);
        if (kind == 1) return t == DLY + TMO;
        if (kind == 2) return gw >= FL && t == ga + DLY;
        return 1'b0;
    endfunction

    function automatic logic e_swap(input int t);
        return w >= FL && t >= a + DLY && t < a + w + DLY;
    endfunction

    task automatic drive(input int t);
        n_bss    = !(kind != 2 && t < bss_end());
        n_booten = !(b && kind != 2 && t < bss_end());
        n_bsen   = (kind == 0) ? !(t >= g && t < g + len) :
                   (kind == 2) ? !(t >= ga && t < ga + gw) : 1'b1;
        n_repen  = (kind == 0) ? !(t >= g + r && t < g + len + 2) : 1'b1;
        n_swapen = !(t >= a && t < a + w);
    endtask

    task automatic check_cycle(input int t);
        chk("shift",  bubble_shift_enable, e_shift(t));
        chk("rep",    replicator_enable,   e_rep(t));
        chk("boot",   bootloop_enable,     e_boot(t));
        chk("swap",   swap_enable,         e_swap(t));
        chk("start",  access_start_tick,   (kind == 0) && t == t_start());
        chk("end",    access_end_tick,     (kind == 0) && t == t_end());
        chk("error",  access_error,        e_err(t));
        chk("onehot", (32'(access_start_tick) + 32'(access_end_tick) + 32'(access_error)) <= 1, 1'b1);
    endtask

    // Entered at #1 after an edge with all strobes idle; ends the same way
    task automatic run_trial(input int horizon);
        for (int t = 0; t < horizon; t++) begin
            drive(t);
            @(posedge master_clock); #1;
            check_cycle(t + 1);
        end
        drive(100000);
    endtask

    task automatic all_high();
        n_bss = 1'b1; n_bsen = 1'b1; n_repen = 1'b1; n_booten = 1'b1; n_swapen = 1'b1;
    endtask

    task automatic check_quiet(input string tag, input int cycles, input bit with_swap);
        for (int i = 0; i < cycles; i++) begin
            @(posedge master_clock); #1;
            chk({tag, "_shift"}, bubble_shift_enable, 1'b0);
            chk({tag, "_rep"},   replicator_enable,   1'b0);
            chk({tag, "_boot"},  bootloop_enable,     1'b0);
            chk({tag, "_start"}, access_start_tick,   1'b0);
            chk({tag, "_end"},   access_end_tick,     1'b0);
            chk({tag, "_err"},   access_error,        1'b0);
            if (with_swap) chk({tag, "_swap"}, swap_enable, 1'b0);
        end
    endtask

    task automatic randomize_trial();
        kind = int'($urandom_range(0, 2));
        g    = int'($urandom_range(0, 40));
        r    = int'($urandom_range(1, 30));
        len  = int'($urandom_range(r + 10, 120));
        b    = 1'($urandom_range(0, 1));
        a    = int'($urandom_range(0, 80));
        w    = int'($urandom_range(1, 40));
        ga   = int'($urandom_range(0, 30));
        gw   = int'($urandom_range(1, 8));
    endtask

    function automatic int horizon_of();
        int h;
        h = (kind == 0) ? g + len : (kind == 1) ? 120 : ga + gw;
        if (a + w > h) h = a + w;
        return h + 20;
    endfunction

    initial begin
        all_high();
        repeat (3) @(posedge master_clock);
        #1;
        chk("rst_shift", bubble_shift_enable, 1'b0);
        chk("rst_boot",  bootloop_enable,     1'b0);
        chk("rst_swap",  swap_enable,         1'b0);
        chk("rst_err",   access_error,        1'b0);
        master_reset = 1'b0;
        check_quiet("idle", 100, 1'b1);

        // Reference access: bss/booten at 0, bsen at 20, repen at 30, bsen release at 500
        kind = 0; g = 20; r = 10; len = 480; b = 1'b1; a = 5; w = 3; ga = 0; gw = 0;
        run_trial(horizon_of());

        // Idle bsen pulses just below and at the filter length
        kind = 2; ga = 2; gw = FL - 1; a = 0; w = 0; b = 1'b0;
        run_trial(horizon_of());
        kind = 2; ga = 2; gw = FL;
        run_trial(horizon_of());

        // Arm timeout with bootloop latched
        kind = 1; b = 1'b1; a = 10; w = 50;
        run_trial(horizon_of());

        // Same-cycle bss/bsen arrival
        kind = 0; g = 0; r = 3; len = 40; b = 1'b0; a = 0; w = 0;
        run_trial(horizon_of());

        for (int n = 0; n < 10; n++) begin
            randomize_trial();
            run_trial(horizon_of());
        end

        // Disable in the middle of SHIFT, then re-enable with bsen still held
        kind = 0; g = 10; r = 2; len = 1000; b = 1'b1; a = 0; w = 2000;
        for (int t = 0; t < 60; t++) begin
            drive(t);
            @(posedge master_clock); #1;
            check_cycle(t + 1);
        end
        chk("pre_dis_shift", bubble_shift_enable, 1'b1);
        bubble_module_enable = 1'b0;
        check_quiet("dis", 10, 1'b1);
        bubble_module_enable = 1'b1;
        @(posedge master_clock); #1;
        chk("reen_swap", swap_enable, 1'b1);
        check_quiet("reen", 20, 1'b0);
        all_high();
        check_quiet("reen_rel", 20, 1'b0);

        // Asynchronous reset in the middle of SHIFT
        kind = 0; g = 10; r = 2; len = 1000; b = 1'b1; a = 0; w = 2000;
        for (int t = 0; t < 60; t++) begin
            drive(t);
            @(posedge master_clock); #1;
            check_cycle(t + 1);
        end
        #3;
        master_reset = 1'b1;
        #1;
        chk("arst_shift", bubble_shift_enable, 1'b0);
        chk("arst_rep",   replicator_enable,   1'b0);
        chk("arst_boot",  bootloop_enable,     1'b0);
        chk("arst_swap",  swap_enable,         1'b0);
        chk("arst_end",   access_end_tick,     1'b0);
        all_high();
        repeat (3) @(posedge master_clock);
        #1;
        master_reset = 1'b0;
        check_quiet("post_rst", 20, 1'b1);

        kind = 0; g = 15; r = 5; len = 60; b = 1'b1; a = 20; w = 30;
        run_trial(horizon_of());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/access_signal_decoder.md
Name: access_signal_decoder

Overview:
- Front-end stage directly upstream of the bubble timing generator.
- Takes the raw active-low bubble-control strobes from the motherboard connector and synchronises and glitch-filters them.
- Sequences them through an access state machine and produces the clean active-high bubble_shift_enable / replicator_enable / bootloop_enable levels the timing generator consumes.
- Also flags protocol errors: shift without start, and start without shift within the timeout.

Parameters:
- FILTER_LEN, 4: consecutive master_clock cycles a synchronised input must hold a new level before the filtered level changes (legal range 1..15).
- ARM_TIMEOUT, 48000: cycles allowed in ARMED before abort (1 ms at 48 MHz).
- TIMEOUT_WIDTH, 16: width of the ARMED timeout counter. Must hold ARM_TIMEOUT-1.

Ports:
- master_clock  in  1  system clock, 48 MHz
- master_reset  in  1  asynchronous, active-high reset
- bubble_module_enable  in  1  from management block. Low forces IDLE and all outputs low.
- n_bss  in  1  raw bubble shift start, active low, asynchronous
- n_bsen  in  1  raw bubble shift enable, active low, asynchronous
- n_repen  in  1  raw replicator enable, active low, asynchronous
- n_booten  in  1  raw bootloop select, active low, asynchronous
- n_swapen  in  1  raw swap gate enable, active low, asynchronous
- bubble_shift_enable  out  1  high while in SHIFT
- replicator_enable  out  1  filtered repen, gated by SHIFT
- bootloop_enable  out  1  booten latched at start, held through the access
- swap_enable  out  1  filtered swapen, gated by bubble_module_enable only
- access_start_tick  out  1  one-cycle pulse on ARMED->SHIFT
- access_end_tick  out  1  one-cycle pulse on SHIFT->IDLE via bsen release
- access_error  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset: every output 0, state IDLE. All synchronisers and filtered levels reset to "deasserted". All counters reset to 0.
- Input path, per input: invert, then a 2-flop synchroniser (s2).
  - Per-input 4-bit stability counter: cleared when s2 equals the filtered level, incremented when they differ.
  - When the counter equals FILTER_LEN-1 and s2 still differs, the filtered level takes s2 on the next edge and the counter clears.
  - A pulse shorter than FILTER_LEN cycles at s2 never reaches the filtered level.
  - Latency from raw edge to filtered level: 2+FILTER_LEN cycles. All outputs are registered, so raw edge to output is 3+FILTER_LEN cycles (7 at default).
- Filtered-edge detection: rise = filtered & ~filtered_d1 (registered previous value).
- FSM states:
  - IDLE: on bss rise go to ARMED, clear the timeout counter, set bootloop_enable = filtered booten. On bsen rise without bss rise, stay IDLE and pulse access_error. Both rising in the same cycle: go to ARMED, no error; the level-sensitive ARMED check then enters SHIFT on the following cycle.
  - ARMED: if bsen is high (level), go to SHIFT and pulse access_start_tick. Otherwise, when the counter reaches ARM_TIMEOUT-1, go to IDLE, pulse access_error and clear bootloop_enable. The counter increments every ARMED cycle and saturates. A further bss rise is ignored.
  - SHIFT: bubble_shift_enable=1, replicator_enable=filtered repen. On bsen fall go to IDLE, pulse access_end_tick, clear bootloop_enable and replicator_enable. bss/booten changes are ignored; bootloop_enable is frozen.
- bubble_module_enable low: next edge forces IDLE, clears all outputs and counters, and emits no ticks (including mid-SHIFT). Synchronisers and filters keep running so levels are valid on re-enable. Edges that occurred while disabled are not replayed: the edge registers track continuously.
- Reset asserted mid-access: immediate return to the reset state. No tick is emitted.
- Tick outputs never overlap. At most one of access_start_tick, access_end_tick, access_error is high per cycle.

Test Plan:
- Reset, all raw inputs high, enable=1 -> all outputs 0 for 100 cycles; state IDLE.
- n_bss low at t0, n_booten low, n_bsen low at t0+20, n_repen low at t0+30, n_bsen high at t0+500 -> ARMED 7 cycles after t0 with bootloop_enable=1. access_start_tick plus bubble_shift_enable rise one cycle after bsen's filtered rise. replicator_enable rises at t0+37. access_end_tick at t0+507; all outputs 0 after.
- 3-cycle low glitch on n_bsen in IDLE -> no output change, no access_error. A 4-cycle low -> exactly one access_error pulse.
- n_bss low, n_bsen never asserted, ARM_TIMEOUT overridden to 100 -> access_error pulse 100 cycles after ARMED entry; return to IDLE, bootloop_enable=0.
- Drop bubble_module_enable mid-SHIFT -> next edge: bubble_shift_enable, replicator_enable, bootloop_enable, swap_enable = 0, no access_end_tick. Re-enable with n_bsen still low -> stays IDLE, no error.
- Assert master_reset asynchronously mid-SHIFT (between clock edges) -> outputs 0 immediately, without waiting for an edge. After release with n_bss/n_bsen high -> IDLE; a fresh start/shift sequence completes normally.
